mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester burst-fair arbiter in front of a one-cycle byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int LGSZW    = 10,
  parameter int MAXBURST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_rq_valid,
  output logic              r0_rq_ready,
  input  logic [31:0]       r0_rq_addr,
  input  logic              r0_rq_iswrite,
  input  logic [31:0]       r0_rq_data,
  input  logic              r0_rq_lock,
  output logic              r0_rs_valid,
  output logic [31:0]       r0_rs_data,
  input  logic              r1_rq_valid,
  output logic              r1_rq_ready,
  input  logic [31:0]       r1_rq_addr,
  input  logic              r1_rq_iswrite,
  input  logic [31:0]       r1_rq_data,
  input  logic              r1_rq_lock,
  output logic              r1_rs_valid,
  output logic [31:0]       r1_rs_data,
  output logic              ram_rq_en,
  output logic [LGSZW+1:0]  ram_addr,
  output logic              ram_write_enable,
  output logic [31:0]       ram_write,
  input  logic              ram_rs_en,
  input  logic [31:0]       ram_read,
  output logic              oob_err
);

  localparam int             CNT_W   = $clog2(MAXBURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAXBURST);

  logic             r_owner;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;
  logic             r_who;
  logic             r_toob;
  logic             r_first;

  logic [1:0]  w_valid;
  logic [1:0]  w_lock;
  logic        w_other;
  logic        w_sel_v;
  logic        w_sel;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_iswrite;
  logic        w_oob;
  logic        w_rs_ok;
  logic [31:0] w_rs_data;

  assign w_valid = {r1_rq_valid, r0_rq_valid};
  assign w_lock  = {r1_rq_lock, r0_rq_lock};
  assign w_other = ~r_owner;

  // Owner keeps the grant while locked, under its burst limit, or uncontested.
  always_comb begin
    w_sel_v = 1'b0;
    w_sel   = r_owner;
    if (resetn) begin
      if (w_valid[r_owner] &&
          (w_lock[r_owner] || (r_count < MAX_CNT) || !w_valid[w_other])) begin
        w_sel_v = 1'b1;
        w_sel   = r_owner;
      end else if (w_valid[w_other]) begin
        w_sel_v = 1'b1;
        w_sel   = w_other;
      end
    end
  end

  assign r0_rq_ready = w_sel_v & ~w_sel;
  assign r1_rq_ready = w_sel_v &  w_sel;

  assign w_addr    = w_sel ? r1_rq_addr    : r0_rq_addr;
  assign w_data    = w_sel ? r1_rq_data    : r0_rq_data;
  assign w_iswrite = w_sel ? r1_rq_iswrite : r0_rq_iswrite;
  assign w_oob     = (w_addr >> (LGSZW + 2)) != 32'd0;

  assign ram_rq_en        = w_sel_v & ~w_oob;
  assign ram_addr         = w_addr[LGSZW+1:0];
  assign ram_write_enable = w_sel_v & ~w_oob & w_iswrite;
  assign ram_write        = w_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= 1'b0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_who   <= 1'b0;
      r_toob  <= 1'b0;
      r_first <= 1'b1;
      oob_err <= 1'b0;
    end else begin
      r_first <= 1'b0;
      r_pend  <= w_sel_v;
      r_who   <= w_sel;
      r_toob  <= w_oob;
      if (w_sel_v) begin
        if (w_sel == r_owner) begin
          r_count <= (r_count == MAX_CNT) ? r_count : r_count + 1'b1;
        end else begin
          r_owner <= w_sel;
          r_count <= CNT_W'(1);
        end
        if (w_oob) begin
          oob_err <= 1'b1;
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  // Out-of-range accesses never touch the RAM, so they answer on the tag alone.
  assign w_rs_ok   = r_pend & (r_toob | ram_rs_en);
  assign w_rs_data = r_toob ? 32'h0 : ram_read;

  assign r0_rs_valid = w_rs_ok & ~r_who;
  assign r1_rs_valid = w_rs_ok &  r_who;
  assign r0_rs_data  = r0_rs_valid ? w_rs_data : 32'h0;
  assign r1_rs_data  = r1_rs_valid ? w_rs_data : 32'h0;

  // A stray response in the first cycle after reset release is silently dropped.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!resetn)
    ram_rs_en |-> (r_pend || r_first))
    else $error("mem_arbiter: ram_rs_en with no pending request");

  a_rsp_missing: assert property (@(posedge clk) disable iff (!resetn)
    (r_pend && !r_toob) |-> ram_rs_en)
    else $error("mem_arbiter: pending RAM request got no ram_rs_en");

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Vector-table and scoreboard bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam logic [31:0] A0  = 32'h0000_0010;
  localparam logic [31:0] A1  = 32'h0000_0020;
  localparam logic [31:0] AOB = 32'h1001_200C;

  logic        clk;
  logic        resetn;
  logic        r0_rq_valid, r0_rq_ready, r0_rq_iswrite, r0_rq_lock, r0_rs_valid;
  logic [31:0] r0_rq_addr, r0_rq_data, r0_rs_data;
  logic        r1_rq_valid, r1_rq_ready, r1_rq_iswrite, r1_rq_lock, r1_rs_valid;
  logic [31:0] r1_rq_addr, r1_rq_data, r1_rs_data;
  logic        ram_rq_en, ram_write_enable, ram_rs_en, oob_err;
  logic [11:0] ram_addr;
  logic [31:0] ram_write, ram_read;

  logic        inj;
  logic        m_rs_en;
  logic [31:0] m_rd;
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  typedef struct {
    bit          rstn, inj;
    bit          v0, l0, w0;
    logic [31:0] a0, d0;
    bit          v1, l1, w1;
    logic [31:0] a1, d1;
    bit          g0, g1;
    string       nm;
  } vec_t;

  typedef struct {
    int          due;
    bit          who;
    logic [31:0] data;
    bit          dchk;
  } rsp_t;

  vec_t tbl[$];
  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   exp_oob = 1'b0;

  mem_arbiter #(.LGSZW(10), .MAXBURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .r0_rq_valid(r0_rq_valid), .r0_rq_ready(r0_rq_ready), .r0_rq_addr(r0_rq_addr),
    .r0_rq_iswrite(r0_rq_iswrite), .r0_rq_data(r0_rq_data), .r0_rq_lock(r0_rq_lock),
    .r0_rs_valid(r0_rs_valid), .r0_rs_data(r0_rs_data),
    .r1_rq_valid(r1_rq_valid), .r1_rq_ready(r1_rq_ready), .r1_rq_addr(r1_rq_addr),
    .r1_rq_iswrite(r1_rq_iswrite), .r1_rq_data(r1_rq_data), .r1_rq_lock(r1_rq_lock),
    .r1_rs_valid(r1_rs_valid), .r1_rs_data(r1_rs_data),
    .ram_rq_en(ram_rq_en), .ram_addr(ram_addr), .ram_write_enable(ram_write_enable),
    .ram_write(ram_write), .ram_rs_en(ram_rs_en), .ram_read(ram_read), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM; read data is the pre-write contents.
  always @(posedge clk) begin
    m_rs_en <= ram_rq_en;
    if (ram_rq_en) begin
      m_rd <= mem[ram_addr[11:2]];
      if (ram_write_enable) mem[ram_addr[11:2]] <= ram_write;
    end
  end
  assign ram_rs_en = m_rs_en | inj;
  assign ram_read  = m_rd;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(bit rstn, bit ij, bit v0, bit l0, bit w0, logic [31:0] a0,
                              logic [31:0] d0, bit v1, bit l1, bit w1, logic [31:0] a1,
                              logic [31:0] d1, bit g0, bit g1, string nm);
    vec_t v;
    v.rstn = rstn; v.inj = ij;
    v.v0 = v0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.nm = nm;
    return v;
  endfunction

  function automatic vec_t idle(string nm);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm);
  endfunction

  task automatic run(input vec_t v);
    rsp_t        e;
    rsp_t        p;
    bit          e0, e1, inr, wr;
    logic [31:0] addr, data;
    @(negedge clk);
    resetn = v.rstn; inj = v.inj;
    r0_rq_valid = v.v0; r0_rq_lock = v.l0; r0_rq_iswrite = v.w0;
    r0_rq_addr = v.a0; r0_rq_data = v.d0;
    r1_rq_valid = v.v1; r1_rq_lock = v.l1; r1_rq_iswrite = v.w1;
    r1_rq_addr = v.a1; r1_rq_data = v.d1;
    if (!v.rstn) begin
      sb.delete();
      exp_oob = 1'b0;
    end
    #4;
    chk({v.nm, ":ready0"}, 32'(r0_rq_ready), 32'(v.g0));
    chk({v.nm, ":ready1"}, 32'(r1_rq_ready), 32'(v.g1));
    e0 = 1'b0; e1 = 1'b0; e.dchk = 1'b0; e.data = 32'h0; e.who = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.who) e1 = 1'b1; else e0 = 1'b1;
    end
    chk({v.nm, ":rs_valid0"}, 32'(r0_rs_valid), 32'(e0));
    chk({v.nm, ":rs_valid1"}, 32'(r1_rs_valid), 32'(e1));
    if (e.dchk) chk({v.nm, ":rs_data"}, e.who ? r1_rs_data : r0_rs_data, e.data);
    if (!v.rstn) begin
      chk({v.nm, ":rs_data0_rst"}, r0_rs_data, 32'h0);
      chk({v.nm, ":rs_data1_rst"}, r1_rs_data, 32'h0);
    end
    chk({v.nm, ":oob_err"}, 32'(oob_err), 32'(exp_oob));
    if (v.g0 || v.g1) begin
      addr = v.g1 ? v.a1 : v.a0;
      data = v.g1 ? v.d1 : v.d0;
      wr   = v.g1 ? v.w1 : v.w0;
      inr  = (addr >> 12) == 32'd0;
      chk({v.nm, ":ram_rq_en"}, 32'(ram_rq_en), 32'(inr));
      if (inr) begin
        chk({v.nm, ":ram_addr"}, 32'(ram_addr), addr & 32'hFFF);
        chk({v.nm, ":ram_we"}, 32'(ram_write_enable), 32'(wr));
        if (wr) chk({v.nm, ":ram_write"}, ram_write, data);
      end
      p.due  = cyc + 1;
      p.who  = v.g1;
      p.data = inr ? shadow[addr[11:2]] : 32'h0;
      p.dchk = !(inr && wr);
      sb.push_back(p);
      if (inr && wr) shadow[addr[11:2]] = data;
      if (!inr) exp_oob = 1'b1;
    end else begin
      chk({v.nm, ":ram_rq_en_idle"}, 32'(ram_rq_en), 32'h0);
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; inj = 1'b0;
    r0_rq_valid = 0; r0_rq_lock = 0; r0_rq_iswrite = 0; r0_rq_addr = 0; r0_rq_data = 0;
    r1_rq_valid = 0; r1_rq_lock = 0; r1_rq_iswrite = 0; r1_rq_addr = 0; r1_rq_data = 0;

    tbl.push_back(mk(0, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 0, 0, "reset"));
    tbl.push_back(mk(0, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 0, 0, "reset"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, A1, 32'hCAFE_0001, 0, 1, "r1_wr"));
    tbl.push_back(idle("idle"));
    tbl.push_back(mk(1, 0, 1, 0, 1, A0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0, "r0_wr"));
    tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 0, 0, 0, 0, 0, 1, 0, "r0_rd"));
    tbl.push_back(idle("idle"));
    tbl.push_back(idle("idle"));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0,
                       (i < 4) || (i >= 8), (i >= 4) && (i < 8), "burst"));
    tbl.push_back(idle("idle"));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0, 1, 1, 0, A0, 0, 1, 0, 0, A1, 0, 1, 0, "lock"));
    tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 0, 1, "unlock"));
    tbl.push_back(idle("idle"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, AOB, 0, 0, 1, "oob_rd"));
    tbl.push_back(idle("oob_sticky"));
    tbl.push_back(idle("oob_sticky"));
    tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 0, 0, 0, 0, 0, 1, 0, "alt_r0"));
    tbl.push_back(idle("alt_idle"));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, A1, 0, 0, 1, "alt_r1"));
    tbl.push_back(idle("alt_idle"));
    tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 0, 0, 0, 0, 0, 1, 0, "alt_r0"));
    tbl.push_back(idle("alt_idle"));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 0, 0, 0, 0, 0, 1, 0, "solo_r0"));
    tbl.push_back(idle("gap"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, i < 4, i == 4, "after_gap"));
    tbl.push_back(idle("idle"));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset pulse right after an accepted read: its response must vanish.
    run(mk(1, 0, 1, 0, 0, A0, 0, 0, 0, 0, 0, 0, 1, 0, "pre_rst_rd"));
    @(posedge clk);
    #1 resetn = 1'b0;
    run(mk(0, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 0, 0, "mid_rst"));
    run(mk(0, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 0, 0, "mid_rst"));
    run(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "stray_rsp"));
    run(mk(1, 0, 1, 0, 0, A0, 0, 1, 0, 0, A1, 0, 1, 0, "post_rst"));
    run(idle("idle"));
    run(idle("idle"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
